// File: rtl/atualiza_tabuleiro.sv
// Write side of the ultimate tic-tac-toe board: validates a move, writes the
// micro cell, scans micro then macro boards for wins/draws, flags game over.
module atualiza_tabuleiro (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic [3:0]  pos_macro,
  input  logic [3:0]  pos_micro,
  input  logic        jogador,
  input  logic [3:0]  endereco_leitura,
  output logic [1:0]  estado_leitura,
  output logic        ocupado,
  output logic        pronto,
  output logic        jogada_invalida,
  output logic        fim_jogo,
  output logic [1:0]  vencedor,
  output logic [17:0] db_macro
);

  typedef enum logic [2:0] {
    OCIOSO,
    ESCREVE,
    VERIFICA_MICRO,
    ATUALIZA_MACRO,
    VERIFICA_MACRO,
    CONCLUI
  } estado_t;

  estado_t state_reg, state_next;

  logic [1:0] micro_reg [81];
  logic [1:0] macro_reg [9];
  logic [3:0] pos_macro_reg, pos_micro_reg;
  logic       jogador_reg;
  logic [2:0] linha_reg;
  logic       vitoria_reg;
  logic       invalida_reg;
  logic       fim_jogo_reg;
  logic [1:0] vencedor_reg;

  logic       pos_macro_valido, pos_micro_valido;
  logic [1:0] marca;
  logic [6:0] base;
  logic [6:0] idx_escrita;
  logic [1:0] macro_alvo;
  logic       movimento_invalido;
  logic [1:0] micro_sub [9];
  logic [8:0] micro_nz, macro_nz;
  logic       micro_cheio, macro_cheio;
  logic [11:0] linha_idx;
  logic [1:0] cel_a, cel_b, cel_c;
  logic       linha_ok;

  // Cell indices {a,b,c} of line k: rows, columns, then diagonals.
  function automatic logic [11:0] indices_linha(input logic [2:0] k);
    case (k)
      3'd0:    return {4'd0, 4'd1, 4'd2};
      3'd1:    return {4'd3, 4'd4, 4'd5};
      3'd2:    return {4'd6, 4'd7, 4'd8};
      3'd3:    return {4'd0, 4'd3, 4'd6};
      3'd4:    return {4'd1, 4'd4, 4'd7};
      3'd5:    return {4'd2, 4'd5, 4'd8};
      3'd6:    return {4'd0, 4'd4, 4'd8};
      default: return {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  assign pos_macro_valido = (pos_macro_reg < 4'd9);
  assign pos_micro_valido = (pos_micro_reg < 4'd9);
  assign marca            = jogador_reg ? 2'b10 : 2'b01;
  // Out-of-range positions are folded to 0 so array indices stay legal.
  assign base        = pos_macro_valido ? 7'(pos_macro_reg) * 7'd9 : 7'd0;
  assign idx_escrita = base + 7'(pos_micro_valido ? pos_micro_reg : 4'd0);
  assign macro_alvo  = pos_macro_valido ? macro_reg[pos_macro_reg] : 2'b00;

  assign movimento_invalido = fim_jogo_reg || !pos_macro_valido || !pos_micro_valido ||
                              (macro_alvo != 2'b00) || (micro_reg[idx_escrita] != 2'b00);

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_celulas
      assign micro_sub[gi] = micro_reg[base + 7'(gi)];
      assign micro_nz[gi]  = (micro_sub[gi] != 2'b00);
      assign macro_nz[gi]  = (macro_reg[gi] != 2'b00);
      assign db_macro[2*gi+1 -: 2] = macro_reg[gi];
    end
  endgenerate

  assign micro_cheio = &micro_nz;
  assign macro_cheio = &macro_nz;

  // One line per cycle; the board under test depends on the scan phase.
  assign linha_idx = indices_linha(linha_reg);
  always_comb begin
    cel_a = micro_sub[linha_idx[11:8]];
    cel_b = micro_sub[linha_idx[7:4]];
    cel_c = micro_sub[linha_idx[3:0]];
    if (state_reg == VERIFICA_MACRO) begin
      cel_a = macro_reg[linha_idx[11:8]];
      cel_b = macro_reg[linha_idx[7:4]];
      cel_c = macro_reg[linha_idx[3:0]];
    end
  end
  assign linha_ok = (cel_a == marca) && (cel_b == marca) && (cel_c == marca);

  always_ff @(posedge clock) begin
    if (reset) state_reg <= OCIOSO;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OCIOSO:         if (iniciar) state_next = ESCREVE;
      ESCREVE:        state_next = movimento_invalido ? CONCLUI : VERIFICA_MICRO;
      VERIFICA_MICRO: if (linha_reg == 3'd7) state_next = ATUALIZA_MACRO;
      ATUALIZA_MACRO: state_next = VERIFICA_MACRO;
      VERIFICA_MACRO: if (linha_reg == 3'd7) state_next = CONCLUI;
      CONCLUI:        state_next = OCIOSO;
      default:        state_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 81; i++) micro_reg[i] <= 2'b00;
      for (int i = 0; i < 9; i++)  macro_reg[i] <= 2'b00;
      pos_macro_reg <= 4'd0;
      pos_micro_reg <= 4'd0;
      jogador_reg   <= 1'b0;
      linha_reg     <= 3'd0;
      vitoria_reg   <= 1'b0;
      invalida_reg  <= 1'b0;
      fim_jogo_reg  <= 1'b0;
      vencedor_reg  <= 2'b00;
    end else begin
      case (state_reg)
        OCIOSO: begin
          invalida_reg <= 1'b0;
          if (iniciar) begin
            pos_macro_reg <= pos_macro;
            pos_micro_reg <= pos_micro;
            jogador_reg   <= jogador;
          end
        end
        ESCREVE: begin
          linha_reg   <= 3'd0;
          vitoria_reg <= 1'b0;
          if (movimento_invalido) invalida_reg <= 1'b1;
          else                    micro_reg[idx_escrita] <= marca;
        end
        VERIFICA_MICRO: begin
          vitoria_reg <= vitoria_reg | linha_ok;
          linha_reg   <= linha_reg + 3'd1;
        end
        ATUALIZA_MACRO: begin
          linha_reg   <= 3'd0;
          vitoria_reg <= 1'b0;
          if (vitoria_reg)      macro_reg[pos_macro_reg] <= marca;
          else if (micro_cheio) macro_reg[pos_macro_reg] <= 2'b11;
        end
        VERIFICA_MACRO: begin
          vitoria_reg <= vitoria_reg | linha_ok;
          linha_reg   <= linha_reg + 3'd1;
          // The last line's result is folded in directly so the flags land with pronto.
          if (linha_reg == 3'd7) begin
            if (vitoria_reg || linha_ok) begin
              fim_jogo_reg <= 1'b1;
              vencedor_reg <= marca;
            end else if (macro_cheio) begin
              fim_jogo_reg <= 1'b1;
              vencedor_reg <= 2'b11;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign estado_leitura  = (endereco_leitura < 4'd9) ? macro_reg[endereco_leitura] : 2'b00;
  assign ocupado         = (state_reg != OCIOSO);
  assign pronto          = (state_reg == CONCLUI);
  assign jogada_invalida = pronto && invalida_reg;
  assign fim_jogo        = fim_jogo_reg;
  assign vencedor        = vencedor_reg;

endmodule

// File: tb/tb_atualiza_tabuleiro.sv
// Scoreboard bench for atualiza_tabuleiro: each request pushes its expected
// outcome; a monitor pops and checks it on every pronto pulse.
module tb_atualiza_tabuleiro;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0;
  logic [3:0]  pos_macro = 4'd0;
  logic [3:0]  pos_micro = 4'd0;
  logic        jogador = 1'b0;
  logic [3:0]  endereco_leitura = 4'd0;
  logic [1:0]  estado_leitura;
  logic        ocupado, pronto, jogada_invalida, fim_jogo;
  logic [1:0]  vencedor;
  logic [17:0] db_macro;

  int testes = 0;
  int falhas = 0;
  int ciclo = 0;

  typedef struct {
    int         inicio;
    int         lat;
    logic       inv;
    logic       fim;
    logic [1:0] venc;
  } esperado_t;

  esperado_t fila[$];

  atualiza_tabuleiro dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .pos_macro(pos_macro), .pos_micro(pos_micro), .jogador(jogador),
    .endereco_leitura(endereco_leitura), .estado_leitura(estado_leitura),
    .ocupado(ocupado), .pronto(pronto), .jogada_invalida(jogada_invalida),
    .fim_jogo(fim_jogo), .vencedor(vencedor), .db_macro(db_macro)
  );

  always #5 clock = ~clock;
  always @(posedge clock) ciclo <= ciclo + 1;

  // Monitor: every pronto must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (pronto === 1'b1) begin
      esperado_t e;
      testes++;
      if (fila.size() == 0) begin
        falhas++;
        $display("FAIL pronto_inesperado: pronto=1 at cycle %0d, required no pronto", ciclo);
      end else begin
        e = fila.pop_front();
        if ((ciclo - e.inicio) !== e.lat) begin
          falhas++;
          $display("FAIL latencia: got %0d, required %0d", ciclo - e.inicio, e.lat);
        end
        testes++;
        if (jogada_invalida !== e.inv) begin
          falhas++;
          $display("FAIL jogada_invalida: got %b, required %b", jogada_invalida, e.inv);
        end
        testes++;
        if (fim_jogo !== e.fim) begin
          falhas++;
          $display("FAIL fim_jogo: got %b, required %b", fim_jogo, e.fim);
        end
        testes++;
        if (vencedor !== e.venc) begin
          falhas++;
          $display("FAIL vencedor: got %b, required %b", vencedor, e.venc);
        end
        $display("[TB] pronto cycle %0d lat=%0d inv=%b fim=%b venc=%b",
                 ciclo, ciclo - e.inicio, jogada_invalida, fim_jogo, vencedor);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic aguardar();
    for (int n = 0; n < 60 && fila.size() != 0; n++) step();
    if (fila.size() != 0) begin
      testes++;
      falhas++;
      $display("FAIL timeout_pronto: %0d requests outstanding, required 0", fila.size());
      fila.delete();
    end
  endtask

  task automatic jogar(input logic [3:0] pm, input logic [3:0] pu, input logic j,
                       input logic inv, input logic fim, input logic [1:0] venc);
    esperado_t e;
    e.inicio = ciclo;
    e.lat    = inv ? 2 : 19;
    e.inv    = inv;
    e.fim    = fim;
    e.venc   = venc;
    fila.push_back(e);
    pos_macro = pm;
    pos_micro = pu;
    jogador   = j;
    iniciar   = 1'b1;
    step();
    iniciar   = 1'b0;
    aguardar();
  endtask

  task automatic aplicar_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    aplicar_reset();
    endereco_leitura = 4'd4;
    #1;
    testes++;
    if ({ocupado, pronto, jogada_invalida, fim_jogo, vencedor} !== 6'b0) begin
      falhas++;
      $display("FAIL reset_saidas: got %b, required 000000",
               {ocupado, pronto, jogada_invalida, fim_jogo, vencedor});
    end
    testes++;
    if (db_macro !== 18'd0 || estado_leitura !== 2'b00) begin
      falhas++;
      $display("FAIL reset_tabuleiro: db_macro=%h estado=%b, required 0/00", db_macro, estado_leitura);
    end
  endtask

  task automatic test_jogada_valida();
    jogar(4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
    endereco_leitura = 4'd4;
    #1;
    testes++;
    if (estado_leitura !== 2'b00) begin
      falhas++;
      $display("FAIL macro4_apos_1: got %b, required 00", estado_leitura);
    end
    jogar(4'd4, 4'd0, 1'b1, 1'b1, 1'b0, 2'b00);
    jogar(4'd9, 4'd0, 1'b1, 1'b1, 1'b0, 2'b00);
    jogar(4'd5, 4'd9, 1'b1, 1'b1, 1'b0, 2'b00);
    testes++;
    if (db_macro !== 18'd0) begin
      falhas++;
      $display("FAIL db_apos_invalidas: got %h, required 0", db_macro);
    end
  endtask

  task automatic test_vitoria_micro();
    logic [3:0] celulas [3] = '{4'd2, 4'd4, 4'd6};
    for (int i = 0; i < 3; i++) jogar(4'd3, celulas[i], 1'b0, 1'b0, 1'b0, 2'b00);
    endereco_leitura = 4'd3;
    #1;
    testes++;
    if (estado_leitura !== 2'b01 || db_macro[7:6] !== 2'b01) begin
      falhas++;
      $display("FAIL macro3_vitoria: estado=%b db=%b, required 01/01", estado_leitura, db_macro[7:6]);
    end
    endereco_leitura = 4'd15;
    #1;
    testes++;
    if (estado_leitura !== 2'b00) begin
      falhas++;
      $display("FAIL leitura_fora: got %b, required 00", estado_leitura);
    end
  endtask

  task automatic test_empate_micro();
    logic jog [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 9; i++) jogar(4'd0, 4'(i), jog[i], 1'b0, 1'b0, 2'b00);
    endereco_leitura = 4'd0;
    #1;
    testes++;
    if (estado_leitura !== 2'b11) begin
      falhas++;
      $display("FAIL macro0_empate: got %b, required 11", estado_leitura);
    end
    jogar(4'd0, 4'd4, 1'b0, 1'b1, 1'b0, 2'b00);
  endtask

  task automatic test_vitoria_jogo();
    logic [17:0] exp_db;
    for (int i = 0; i < 3; i++) jogar(4'd2, 4'(i), 1'b1, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) jogar(4'd6, 4'(i), 1'b1, 1'b0, 1'b0, 2'b00);
    jogar(4'd4, 4'd1, 1'b1, 1'b0, 1'b0, 2'b00);
    jogar(4'd4, 4'd4, 1'b1, 1'b0, 1'b0, 2'b00);
    jogar(4'd4, 4'd7, 1'b1, 1'b0, 1'b1, 2'b10);
    exp_db = 18'd0;
    exp_db[1:0]   = 2'b11;
    exp_db[5:4]   = 2'b10;
    exp_db[7:6]   = 2'b01;
    exp_db[9:8]   = 2'b10;
    exp_db[13:12] = 2'b10;
    testes++;
    if (db_macro !== exp_db) begin
      falhas++;
      $display("FAIL db_macro_final: got %h, required %h", db_macro, exp_db);
    end
    jogar(4'd8, 4'd8, 1'b0, 1'b1, 1'b1, 2'b10);
  endtask

  task automatic test_reset_meio();
    aplicar_reset();
    pos_macro = 4'd4;
    pos_micro = 4'd0;
    jogador   = 1'b0;
    iniciar   = 1'b1;
    step();
    iniciar = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    endereco_leitura = 4'd4;
    #1;
    testes++;
    if ({ocupado, pronto, jogada_invalida, fim_jogo, vencedor} !== 6'b0 || db_macro !== 18'd0) begin
      falhas++;
      $display("FAIL reset_meio: got %b db=%h, required 000000 db=0",
               {ocupado, pronto, jogada_invalida, fim_jogo, vencedor}, db_macro);
    end
    for (int i = 0; i < 25; i++) step();
    // The micro cell written before the reset must be free again.
    jogar(4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic test_ocupado_ignora();
    esperado_t e;
    e.inicio = ciclo;
    e.lat    = 19;
    e.inv    = 1'b0;
    e.fim    = 1'b0;
    e.venc   = 2'b00;
    fila.push_back(e);
    pos_macro = 4'd1;
    pos_micro = 4'd0;
    jogador   = 1'b0;
    iniciar   = 1'b1;
    step();
    iniciar   = 1'b0;
    testes++;
    if (ocupado !== 1'b1) begin
      falhas++;
      $display("FAIL ocupado_T1: got %b, required 1", ocupado);
    end
    step();
    pos_macro = 4'd9;
    pos_micro = 4'd9;
    iniciar   = 1'b1;
    step();
    iniciar   = 1'b0;
    aguardar();
    for (int i = 0; i < 25; i++) step();
    // The first request used the latched inputs, not the ones changed mid-flight.
    jogar(4'd1, 4'd0, 1'b1, 1'b1, 1'b0, 2'b00);
  endtask

  initial begin
    test_reset();
    test_jogada_valida();
    test_vitoria_micro();
    test_empate_micro();
    test_vitoria_jogo();
    test_reset_meio();
    test_ocupado_ignora();
    for (int i = 0; i < 5; i++) step();
    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
